pulpemu_clk_div_bank: RTL and testbench

Multi-channel, runtime-programmable clock divider for the FPGA emulation top; successor to the fixed single-divisor reference/LED divider. It derives N_CH divided clocks and per-channel enable ticks from one FPGA clock, e.g. the 32768 Hz reference, the LED blink and peripheral strobes. Divisors reload glitch-free at period boundaries through a valid/ready configuration port.

---
 rtl/pulpemu_clk_div_bank.sv | 137 +++++++++++++
 tb/tb_pulpemu_clk_div_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpemu_clk_div_bank.sv
// Multi-channel runtime-programmable clock divider with per-channel enable ticks.
// Optional phase-align input enabled by defining PULPEMU_CLK_DIV_SYNC_EN.
module pulpemu_clk_div_bank #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 256,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic [N_CH-1:0]  cfg_pending_o,
  input  logic             sync_i,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0] div_q  [N_CH];
  logic [CNT_W-1:0] div_d  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [CNT_W-1:0] pdiv_q [N_CH];
  logic [CNT_W-1:0] pdiv_d [N_CH];
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  clk_q;
  logic [N_CH-1:0]  clk_d;
  logic [N_CH-1:0]  tick_q;
  logic [N_CH-1:0]  tick_d;
  logic [N_CH-1:0]  bnd;
  logic [N_CH-1:0]  wrap;
  logic             ch_valid;
  logic             sel_pend;
  logic             cfg_fire;
  logic             sync_hit;

`ifdef PULPEMU_CLK_DIV_SYNC_EN
  assign sync_hit = sync_i;
`else
  logic unused_sync;
  assign unused_sync = sync_i;
  assign sync_hit    = 1'b0;
`endif

  // Config handshake: a write transfers in any cycle with cfg_valid_i && cfg_ready_o.
  // Ready drops only while the selected channel already holds an unapplied divisor;
  // out-of-range channels are always ready and the write is discarded.
  assign ch_valid = ({1'b0, cfg_ch_i} < (CH_W + 1)'(N_CH));

  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch_i == CH_W'(i)) sel_pend = pend_q[i];
    end
  end

  assign cfg_ready_o = !(ch_valid && sel_pend);
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;

  // A period boundary is the last count of a period; d <= 1 has one every cycle.
  always_comb begin
    bnd  = '0;
    wrap = '0;
    for (int i = 0; i < N_CH; i++) begin
      bnd[i]  = (div_q[i] <= ONE) || (cnt_q[i] == div_q[i] - ONE);
      wrap[i] = bnd[i] || (sync_hit && (div_q[i] != '0));
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      pend_d[i] = pend_q[i];
      clk_d[i]  = 1'b0;
      tick_d[i] = 1'b0;

      if (wrap[i]) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // Ready guarantees pend_q is clear here, so this never races the reload clear.
      if (cfg_fire && ch_valid && (cfg_ch_i == CH_W'(i))) begin
        pdiv_d[i] = cfg_div_i;
        pend_d[i] = 1'b1;
      end

      if (div_d[i] >= TWO) begin
        clk_d[i]  = (cnt_d[i] >= (div_d[i] >> 1));
        tick_d[i] = (cnt_d[i] == div_d[i] - ONE);
      end else if (div_d[i] == ONE) begin
        tick_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_RST;
        pdiv_q[i] <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign cfg_pending_o = pend_q;
  assign clk_o         = clk_q;
  assign tick_o        = tick_q;

endmodule

// File: tb/tb_pulpemu_clk_div_bank.sv
// Bench for pulpemu_clk_div_bank: write table, boundary/sync/reset sequences,
// and a per-cycle scoreboard of {pending, tick, clk} built from divisor epochs.
module tb_pulpemu_clk_div_bank;

  // Three channels leave channel code 3 free to exercise an out-of-range write.
  localparam int NCH  = 3;
  localparam int CW   = 16;
  localparam int DDIV = 256;
  localparam int CHW  = 2;
  localparam int W    = 3 * NCH;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           sync = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic           cfg_ready;
  logic [NCH-1:0] pend_o;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] tick_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;

  // Expected timeline per channel: current divisor from a start cycle, plus an
  // optional queued divisor taking over at the predicted reload cycle.
  int cd[NCH];
  int cs[NCH];
  int nd[NCH];
  int ns[NCH];
  int wc[NCH];
  bit has_new[NCH];

  typedef struct {
    int gap;
    int ch;
    int div;
    bit ready;
  } wr_vec_t;

  wr_vec_t vecs[9];

  pulpemu_clk_div_bank #(
    .N_CH(NCH),
    .CNT_W(CW),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch),
    .cfg_div_i(cfg_div),
    .cfg_pending_o(pend_o),
    .sync_i(sync),
    .clk_o(clk_o),
    .tick_o(tick_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- expectation model ----------------
  function automatic logic [2:0] chan_exp(input int ch, input int x);
    int d;
    int s;
    int k;
    logic p;
    d = cd[ch];
    s = cs[ch];
    if (has_new[ch] && x >= ns[ch]) begin
      d = nd[ch];
      s = ns[ch];
    end
    p = has_new[ch] && (x > wc[ch]) && (x < ns[ch]);
    if (d == 0) return {p, 1'b0, 1'b0};
    if (d == 1) return {p, 1'b1, 1'b0};
    k = (x - s) % d;
    return {p, (k == d - 1), (k >= d / 2)};
  endfunction

  function automatic logic [W-1:0] model(input int x);
    logic [W-1:0] r;
    logic [2:0] e;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      e = chan_exp(ch, x);
      r[ch]         = e[0];
      r[NCH + ch]   = e[1];
      r[2*NCH + ch] = e[2];
    end
    return r;
  endfunction

  function automatic int next_start(input int ch, input int t);
    int d;
    int s;
    d = cd[ch];
    s = cs[ch];
    if (d <= 1) return t + 2;
    for (int c = t + 1; c <= t + d; c++) begin
      if ((c - s) % d == d - 1) return c + 1;
    end
    return t + 2;
  endfunction

  task automatic model_init();
    for (int ch = 0; ch < NCH; ch++) begin
      cd[ch] = DDIV;
      cs[ch] = 0;
      nd[ch] = 0;
      ns[ch] = 0;
      wc[ch] = 0;
      has_new[ch] = 1'b0;
    end
  endtask

  task automatic fold(input int ch);
    if (has_new[ch] && cyc >= ns[ch]) begin
      cd[ch] = nd[ch];
      cs[ch] = ns[ch];
      has_new[ch] = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) exp_q.push_back(model(cyc));
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {pend_o, tick_o, clk_o};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL cycle%0d {pending,tick,clk}: got %b want %b", cyc, mon_got, mon_exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("reset ready", cfg_ready, 1);
    check("reset pending", pend_o, 0);
    check("reset clk", clk_o, 0);
    check("reset tick", tick_o, 0);
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    model_init();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wr(input int ch, input int div, input bit exp_ready, input string name);
    cfg_ch = CHW'(ch);
    cfg_div = CW'(div);
    cfg_valid = 1'b1;
    #1;
    check(name, cfg_ready, exp_ready);
    if (exp_ready && ch < NCH) begin
      fold(ch);
      nd[ch] = div;
      wc[ch] = cyc;
      ns[ch] = next_start(ch, cyc);
      has_new[ch] = 1'b1;
    end
    @(posedge clk);
    #2;
    cfg_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int k;
    vecs[0] = '{gap: 300, ch: 1, div: 5, ready: 1'b1};
    vecs[1] = '{gap: 2,   ch: 1, div: 7, ready: 1'b0};
    vecs[2] = '{gap: 0,   ch: 2, div: 0, ready: 1'b1};
    vecs[3] = '{gap: 3,   ch: 3, div: 9, ready: 1'b1};
    vecs[4] = '{gap: 260, ch: 2, div: 1, ready: 1'b1};
    vecs[5] = '{gap: 0,   ch: 0, div: 3, ready: 1'b1};
    vecs[6] = '{gap: 1,   ch: 0, div: 9, ready: 1'b0};
    vecs[7] = '{gap: 0,   ch: 1, div: 6, ready: 1'b1};
    vecs[8] = '{gap: 260, ch: 0, div: 4, ready: 1'b1};

    model_init();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].gap);
      wr(vecs[i].ch, vecs[i].div, vecs[i].ready, $sformatf("wr%0d ready", i));
    end
    step(20);

    // Same-value write issued exactly on ch1's last count: waits a whole extra period.
    fold(1);
    k = (cyc - cs[1]) % cd[1];
    step(cd[1] - 1 - k);
    wr(1, 6, 1'b1, "boundary-cycle write ready");
    step(10);
    // Write one count before the boundary: reloads right after it.
    fold(1);
    k = (cyc - cs[1]) % cd[1];
    step((cd[1] - 2 - k + cd[1]) % cd[1]);
    wr(1, 6, 1'b1, "pre-boundary write ready");
    step(10);

    // Phase-align pulse; without the feature every channel keeps its phase.
    for (int ch = 0; ch < NCH; ch++) fold(ch);
    sync = 1'b1;
`ifdef PULPEMU_CLK_DIV_SYNC_EN
    for (int ch = 0; ch < NCH; ch++) begin
      if (cd[ch] != 0) cs[ch] = cyc + 1;
    end
`endif
    step(1);
    sync = 1'b0;
    step(30);

    // Reset while an update is pending: the update must be lost.
    wr(0, 2, 1'b1, "pre-reset write ready");
    step(1);
    do_reset();
    step(270);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
